// File: rtl/snake_body_buffer_if.sv
// Push/grow/tail handshake bundle between the head datapath, the body buffer and the VGA erase writer.
// master = head datapath / writer side, slave = snake_body_buffer.
interface snake_body_buffer_if #(
  parameter int COORD_W = 7,
  parameter int LEN_W   = 6
);
  logic               push;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               grow;
  logic               tail_ack;
  logic               busy;
  logic               done;
  logic               collide;
  logic               tail_valid;
  logic [COORD_W-1:0] tail_x;
  logic [COORD_W-1:0] tail_y;
  logic [LEN_W-1:0]   len;

  modport master (
    output push, head_x, head_y, grow, tail_ack,
    input  busy, done, collide, tail_valid, tail_x, tail_y, len
  );

  modport slave (
    input  push, head_x, head_y, grow, tail_ack,
    output busy, done, collide, tail_valid, tail_x, tail_y, len
  );
endinterface

// File: rtl/snake_body_buffer.sv
// Snake body ring buffer: scans for self-collision, commits the head, pops the tail at target length.
// Latency N+2 cycles (N = cells scanned); busy blocks pushes until done and any popped tail is acked.
module snake_body_buffer #(
  parameter int MAX_LEN   = 32,
  parameter int INIT_LEN  = 3,
  parameter int GROW_STEP = 1,
  parameter int COORD_W   = 7
) (
  input logic               clk,
  input logic               reset,
  snake_body_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DONE} state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] x_mem [MAX_LEN];
  logic [COORD_W-1:0] y_mem [MAX_LEN];

  logic [PTR_W-1:0]   wr_ptr, rd_ptr, scan_addr;
  logic [LEN_W-1:0]   count, target_len, target_len_nxt, scan_idx;
  logic               grow_pend, excl, excl_nxt;
  logic               accept, tail_pop, scan_last, scan_hit;
  logic [COORD_W-1:0] head_x_q, head_y_q;
  logic               busy_q, done_q, collide_q, tail_valid_q, tail_valid_nxt;
  logic [COORD_W-1:0] tail_x_q, tail_y_q;
  int                 tl_sum;

  // Target length as seen this cycle: pending and same-cycle grows only land while IDLE.
  always_comb begin
    tl_sum = int'(target_len);
    if (state == IDLE) begin
      if (bus.grow)  tl_sum = tl_sum + GROW_STEP;
      if (grow_pend) tl_sum = tl_sum + GROW_STEP;
    end
    target_len_nxt = (tl_sum > MAX_LEN) ? LEN_W'(MAX_LEN) : tl_sum[LEN_W-1:0];
  end

  always_comb begin
    accept    = (state == IDLE) && !tail_valid_q && bus.push;
    excl_nxt  = (count == target_len_nxt);
    tail_pop  = (count == target_len);
    scan_addr = rd_ptr + PTR_W'(excl) + PTR_W'(scan_idx);
    scan_last = (scan_idx == count - LEN_W'(excl) - LEN_W'(1));
    scan_hit  = (x_mem[scan_addr] == head_x_q) && (y_mem[scan_addr] == head_y_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (count == LEN_W'(excl_nxt)) ? COMMIT : SCAN;
      SCAN:    if (scan_last) state_nxt = COMMIT;
      COMMIT:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    tail_valid_nxt = tail_valid_q;
    if (bus.tail_ack) tail_valid_nxt = 1'b0;
    if ((state == COMMIT) && tail_pop) tail_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      target_len   <= LEN_W'(INIT_LEN);
      grow_pend    <= 1'b0;
      scan_idx     <= '0;
      excl         <= 1'b0;
      head_x_q     <= '0;
      head_y_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      collide_q    <= 1'b0;
      tail_valid_q <= 1'b0;
      tail_x_q     <= '0;
      tail_y_q     <= '0;
    end else begin
      busy_q       <= (state_nxt != IDLE) || tail_valid_nxt;
      done_q       <= (state_nxt == DONE);
      tail_valid_q <= tail_valid_nxt;

      if (state == IDLE) begin
        target_len <= target_len_nxt;
        grow_pend  <= 1'b0;
      end else if (bus.grow) begin
        grow_pend  <= 1'b1;
      end

      if (accept) begin
        head_x_q  <= bus.head_x;
        head_y_q  <= bus.head_y;
        collide_q <= 1'b0;
        excl      <= excl_nxt;
        scan_idx  <= '0;
      end

      if (state == SCAN) begin
        if (scan_hit) collide_q <= 1'b1;
        scan_idx <= scan_idx + LEN_W'(1);
      end

      // At full length the oldest cell is read out before this edge's write can overwrite it.
      if (state == COMMIT) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (tail_pop) begin
          tail_x_q <= x_mem[rd_ptr];
          tail_y_q <= y_mem[rd_ptr];
          rd_ptr   <= rd_ptr + PTR_W'(1);
        end else begin
          count    <= count + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == COMMIT) begin
      x_mem[wr_ptr] <= head_x_q;
      y_mem[wr_ptr] <= head_y_q;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.collide    = collide_q;
  assign bus.tail_valid = tail_valid_q;
  assign bus.tail_x     = tail_x_q;
  assign bus.tail_y     = tail_y_q;
  assign bus.len        = count;
endmodule
